// File: rtl/audio_pkt_pkg.sv
// Shared definitions for the audio packet format: field slices, checksum rule
// and the transmit FSM encoding.
package audio_pkt_pkg;

    localparam int CHK_MSB  = 31;
    localparam int CHK_LSB  = 24;
    localparam int DEV_MSB  = 23;
    localparam int DEV_LSB  = 16;
    localparam int SEQ_MSB  = 15;
    localparam int SEQ_LSB  = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_RESP = 2'd2
    } pkt_state_t;

    function automatic logic [7:0] pkt_checksum(input logic [7:0] dev,
                                                input logic [7:0] seq,
                                                input logic [7:0] data);
        return dev ^ seq ^ data;
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous sample FIFO with occupancy count; push and pop may coincide.
module audio_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/audio_packet_builder.sv
// Builds {chk, dev, seq, data} packets from buffered samples, sends each with a
// one-cycle valid pulse and retries or drops on reject/timeout.
//  state        | meaning
//  ST_IDLE      | waiting for a buffered sample; loads packet_out on exit
//  ST_SEND      | packet_valid pulse, response timer cleared
//  ST_WAIT_RESP | sampling accept/reject while the timer runs
module audio_packet_builder
    import audio_pkt_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_RETRY    = 2,
    parameter int RESP_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   sample_in,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    input  logic [7:0]                   dev_id_cfg,
    output logic [31:0]                  packet_out,
    output logic                         packet_valid,
    input  logic                         packet_accepted,
    input  logic                         packet_rejected,
    output logic                         tx_busy,
    output logic                         drop_pulse,
    output logic [7:0]                   seq_num_out,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(RESP_TIMEOUT - 1);

    pkt_state_t    state, state_next;
    logic [7:0]    seq;
    logic [RW-1:0] retry_cnt;
    logic [TW-1:0] timer;
    logic [7:0]    fifo_head;
    logic          fifo_full, fifo_empty, avail_q;
    logic          push, pop, load, retry, drop;
    logic          resp_ok, resp_fail;

    assign sample_ready = !fifo_full;
    assign push         = sample_valid && sample_ready;

    audio_sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (sample_in),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign packet_valid = (state == ST_SEND);
    assign tx_busy      = (state != ST_IDLE);
    assign seq_num_out  = seq;
    assign resp_ok      = packet_accepted && !packet_rejected;
    assign resp_fail    = packet_rejected || (timer == TIMER_LAST);

    // avail_q delays IDLE by one cycle after a sample lands in an empty buffer,
    // but back-to-back packets still leave IDLE immediately.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        retry      = 1'b0;
        drop       = 1'b0;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (avail_q && !fifo_empty) begin
                    load       = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: state_next = ST_WAIT_RESP;
            ST_WAIT_RESP: begin
                if (resp_ok) begin
                    pop        = 1'b1;
                    state_next = ST_IDLE;
                end else if (resp_fail) begin
                    if (retry_cnt < RETRY_LIMIT) begin
                        retry      = 1'b1;
                        state_next = ST_SEND;
                    end else begin
                        drop       = 1'b1;
                        pop        = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq        <= '0;
            retry_cnt  <= '0;
            timer      <= '0;
            avail_q    <= 1'b0;
            drop_pulse <= 1'b0;
            packet_out <= '0;
        end else begin
            avail_q    <= !fifo_empty;
            drop_pulse <= drop;
            timer      <= (state == ST_WAIT_RESP) ? timer + 1'b1 : '0;
            if (pop) begin
                seq       <= seq + 8'd1;
                retry_cnt <= '0;
            end else if (retry) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
            if (load) begin
                packet_out[CHK_MSB:CHK_LSB]   <= pkt_checksum(dev_id_cfg, seq, fifo_head);
                packet_out[DEV_MSB:DEV_LSB]   <= dev_id_cfg;
                packet_out[SEQ_MSB:SEQ_LSB]   <= seq;
                packet_out[DATA_MSB:DATA_LSB] <= fifo_head;
            end
        end
    end

endmodule

// File: doc/audio_packet_builder.md
Name: audio_packet_builder

Overview:
- Transmit-side counterpart of the audio packet processor. Builds the 32-bit packet {checksum, device_id, sequence_num, audio_data} that the processor consumes.
- Buffers 8-bit audio samples in a small FIFO, stamps each with the configured device ID and an auto-incrementing sequence number, and computes checksum = dev ^ seq ^ data.
- Sends each packet with a one-cycle valid pulse, then waits for the processor's accept/reject response, retrying or dropping as required.

Parameters:
- FIFO_DEPTH, 4, sample buffer entries (power of 2, ≥2)
- MAX_RETRY, 2, resends allowed after the first attempt before a packet is dropped
- RESP_TIMEOUT, 16, cycles spent in WAIT_RESP without a response before it counts as a reject

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- sample_in  in  8  audio sample
- sample_valid  in  1  sample offered
- sample_ready  out  1  FIFO can accept; equals !full, registered-state-derived
- dev_id_cfg  in  8  device ID to stamp on packets
- packet_out  out  32  {chk[31:24], dev[23:16], seq[15:8], data[7:0]}
- packet_valid  out  1  one-cycle pulse per send attempt
- packet_accepted  in  1  processor accept response
- packet_rejected  in  1  processor reject response
- tx_busy  out  1  high whenever state != IDLE
- drop_pulse  out  1  one-cycle pulse when a packet is abandoned
- seq_num_out  out  8  next sequence number to be used
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset values: all outputs 0 except sample_ready=1. FIFO is emptied, seq=0x00, retry_cnt=0, timer=0, state=IDLE. Reset mid-operation aborts any packet silently, with no drop_pulse.
- Push: occurs on a clock edge where sample_valid && sample_ready.
- Pop: occurs only when a packet completes (accepted or dropped).
- Simultaneous push and pop in one cycle is legal and leaves the count unchanged. sample_ready does not depend on the same-cycle pop.
- FSM states: IDLE, SEND, WAIT_RESP.
- IDLE: if the FIFO is non-empty, go to SEND.
  - packet_out is registered from the FIFO head, dev_id_cfg and seq on this transition.
  - Checksum is the 8-bit XOR of dev, seq and data.
- SEND: packet_valid=1 for exactly one cycle; timer cleared; go to WAIT_RESP.
- WAIT_RESP: responses are sampled only in this state. Responses arriving during SEND are ignored.
  - accepted (and not rejected): pop, seq+1, retry_cnt=0, go to IDLE.
  - rejected, or timer reaching RESP_TIMEOUT-1 with no response: this is a failure.
  - Failure with retry_cnt < MAX_RETRY: retry_cnt+1, go to SEND. Identical packet_out; dev_id_cfg is not re-sampled.
  - Failure otherwise: drop_pulse=1, pop, seq+1, retry_cnt=0, go to IDLE.
  - accepted and rejected both high: treated as reject.
- Latency: sample pushed at edge N → packet_valid high in the cycle after edge N+2 (IDLE at N+1, SEND at N+2), if the block is idle.
- packet_out holds its value after SEND until the next IDLE→SEND load.
- seq is 8-bit and wraps 0xFF→0x00. It advances per packet, not per attempt, including on drops.
- Back-to-back throughput: one packet per 3 cycles minimum (SEND, WAIT_RESP with an immediate response, IDLE).

Decomposition:
- Shared package audio_pkt_pkg:
  - field slice constants CHK_MSB/LSB, DEV_MSB/LSB, SEQ_MSB/LSB, DATA_MSB/LSB
  - function pkt_checksum(dev, seq, data)
  - FSM state encoding
  - The processor should adopt the same package.
- One sub-module: audio_sample_fifo. Synchronous FIFO, parameterised depth/width, outputs count/full/empty, pop and push allowed in the same cycle.

Test Plan:
- Basic accept: dev_id_cfg=0xA5, push 0xAB, accept one cycle after packet_valid → packet_out=0x0EA500AB, exactly one valid pulse, seq_num_out becomes 0x01, tx_busy drops.
- Second packet: then push 0x55 with immediate accept → packet_out=0xF1A50155.
- Retry then drop: from reset, dev=0x5A, push 0xCD, reject every attempt → three valid pulses each carrying 0x975A00CD, then drop_pulse once, seq=0x01, fifo_count=0.
- Timeout: dev=0xA5, push 0xAB, no response → second packet_valid exactly RESP_TIMEOUT+1 cycles after the first, same payload. Accept on the 2nd attempt → no drop, seq=0x01.
- Backpressure: push 5 samples back-to-back with responses withheld → sample_ready low after the 4th push, fifo_count=4. After the first accept, sample_ready rises and the 5th is accepted. Packets emerge in order with seq 0,1,2,3,4.
- Wrap and reset: force 256 accepted packets → the 257th carries seq 0x00. Assert rst during WAIT_RESP → all outputs 0 immediately (async), sample_ready=1, no drop_pulse, next packet uses seq 0x00.
